stream_cipher_w: RTL and testbench
==================================

Name: stream_cipher_w

Overview:
- Parametrised successor to the single-bit three-LFSR stream cipher.
- Three Fibonacci LFSRs with programmable lengths, taps and runtime-loadable seeds feed the combiner ks = (a & b) ^ c.
- The LFSRs are unrolled W steps per clock so that one W-bit data word is encrypted or decrypted per accepted beat.
- Adds a seed-load/warm-up state machine and valid/ready streaming on both sides; sits between the data source and the link framer.

Parameters:
W, 8, data word width in bits (1..32); keystream bits generated per accepted beat
N1, 5, LFSR1 length
N2, 7, LFSR2 length
N3, 9, LFSR3 length
TAPS1, 5'b10100, LFSR1 feedback mask (bit i set => state[i] in XOR)
TAPS2, 7'b1100000, LFSR2 feedback mask
TAPS3, 9'b100010000, LFSR3 feedback mask
WARMUP, 16, single-bit LFSR steps discarded after seed load (0 allowed)

Ports:
clk  in  1  clock, rising edge
reset  in  1  asynchronous, active-low reset
seed1  in  N1  LFSR1 seed
seed2  in  N2  LFSR2 seed
seed3  in  N3  LFSR3 seed
load  in  1  one-cycle pulse; captures seeds and restarts the cipher
busy  out  1  high in LOAD/WARMUP
s_valid  in  1  input word valid
s_ready  out  1  input word accepted when s_valid & s_ready
s_data  in  W  plaintext or ciphertext word
m_valid  out  1  output word valid
m_ready  in  1  downstream ready
m_data  out  W  s_data XOR keystream word

Behaviour:
- Reset (reset=0, async): state IDLE; all LFSRs 0; m_valid=0, m_data=0, busy=0, s_ready=0.
- LFSR single step: out = state[N-1]; fb = ^(state & TAPS); next = {state[N-2:0], fb}. Keystream bit = (out1 & out2) ^ out3.
- Word keystream: ks[j] is the bit from sub-step j (j=0 uses the current state); LSB is the first bit. A word advances every LFSR by exactly W steps.
- Zero-seed guard: a seed of all zeros is replaced by 1 (LSB set) at capture.
- FSM states and transitions:
  - IDLE: s_ready=0. load -> LOAD.
  - LOAD: one cycle; capture the seeds and the warm-up counter = WARMUP. Next state is WARMUP if WARMUP>0, else RUN.
  - WARMUP: the LFSRs advance min(W, remaining) steps per cycle. The counter decrements by that amount. At 0 -> RUN. Cycles in WARMUP = ceil(WARMUP/W).
  - RUN: s_ready = !m_valid | m_ready. On accept: m_data <= s_data ^ ks, m_valid <= 1, LFSRs advance W steps. m_valid clears on m_ready & !accept.
- Output register is one stage: latency from accept to m_valid is 1 cycle. Throughput is one word per cycle when m_ready is held high.
- Backpressure: while m_valid & !m_ready, m_data and m_valid hold, s_ready=0, LFSRs frozen.
- load in any state (including mid-RUN): pending m_valid is dropped (m_valid <= 0), the current input beat is not accepted, and the FSM goes to LOAD. load has priority over accept in the same cycle.
- busy = (state==LOAD)|(state==WARMUP).
- Decryption uses an identical instance with identical seeds; the XOR is symmetric.
- Async reset mid-operation: immediate return to reset values; seeds must be reloaded.

Optional Feature:
- Macro: STREAM_CIPHER_WORD_COUNT_EN.
- Defined: adds output port word_count, 32 bits. It resets to 0, clears on load, increments on each accepted input beat, and wraps from 0xFFFFFFFF to 0.
- Undefined: the port and counter are absent; all other behaviour is identical.

Test Plan:
- W=4, WARMUP=0, seeds 5'b10101/7'b1101101/9'b101110011, load, then s_data=4'h0 with m_ready=1 -> m_data=4'hC one cycle after accept; s_data=4'hF on the first word instead -> 4'h3.
- Loopback: encrypt 256 random W=8 words, then decrypt with a second instance using the same seeds and WARMUP=16 -> output equals the original stream. The first s_ready occurs 1+2 cycles after load.
- Backpressure: hold m_ready=0 for 5 cycles with m_valid=1 -> m_data stable, s_ready=0, and the next word's keystream equals the no-stall run.
- Zero seeds (all 0) loaded -> the LFSRs start at 1. Keystream is not constant zero over 64 words.
- load asserted mid-RUN while m_valid=1 and s_valid=1 -> m_valid drops next cycle, beat not accepted, busy=1. The first RUN word matches the post-load reference.
- Async reset asserted between clock edges during WARMUP -> outputs return to 0 immediately. With STREAM_CIPHER_WORD_COUNT_EN defined, word_count=0 and it counts 10 after 10 accepts.

Source files
------------

// File: rtl/stream_cipher_w.sv
// stream_cipher_w: word-wide three-LFSR stream cipher, keystream ks = (a & b) ^ c,
// with each LFSR unrolled W steps per accepted beat.
// Latency: 1 cycle from input accept to m_valid. Throughput: one word per cycle while m_ready is high.
// Backpressure: s_ready = !m_valid | m_ready in RUN; while stalled, the output holds and the LFSRs freeze.
// Ports: clk/reset (async active-low); seed1..3 + load (restart, seeds captured in LOAD);
//        busy (LOAD/WARMUP); s_valid/s_ready/s_data input stream; m_valid/m_ready/m_data output stream.
// Optional: define STREAM_CIPHER_WORD_COUNT_EN to add word_count[31:0] (accepted beats, cleared on load).
module stream_cipher_w #(
  parameter int              W      = 8,
  parameter int              N1     = 5,
  parameter int              N2     = 7,
  parameter int              N3     = 9,
  parameter logic [N1-1:0]   TAPS1  = 5'b10100,
  parameter logic [N2-1:0]   TAPS2  = 7'b1100000,
  parameter logic [N3-1:0]   TAPS3  = 9'b100010000,
  parameter int              WARMUP = 16
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [N1-1:0] seed1,
  input  logic [N2-1:0] seed2,
  input  logic [N3-1:0] seed3,
  input  logic          load,
  output logic          busy,
  input  logic          s_valid,
  output logic          s_ready,
  input  logic [W-1:0]  s_data,
  output logic          m_valid,
  input  logic          m_ready,
  output logic [W-1:0]  m_data
`ifdef STREAM_CIPHER_WORD_COUNT_EN
  ,
  output logic [31:0]   word_count
`endif
);

  localparam logic [31:0] W_U      = 32'(W);
  localparam logic [31:0] WARMUP_U = 32'(WARMUP);

  typedef enum logic [1:0] {ST_IDLE, ST_LOAD, ST_WARMUP, ST_RUN} state_e;

  state_e        state_q, state_d;
  logic [N1-1:0] lfsr1_q, lfsr1_d;
  logic [N2-1:0] lfsr2_q, lfsr2_d;
  logic [N3-1:0] lfsr3_q, lfsr3_d;
  logic [31:0]   warm_q, warm_d;
  logic          m_valid_q, m_valid_d;
  logic [W-1:0]  m_data_q, m_data_d;

  logic [31:0]   warm_step;
  logic [W-1:0]  ks;
  logic [N1-1:0] run1, warm1;
  logic [N2-1:0] run2, warm2;
  logic [N3-1:0] run3, warm3;
  logic          accept;

  // Warm-up advances at most W steps per cycle; the last cycle may be partial.
  always_comb begin
    warm_step = (warm_q < W_U) ? warm_q : W_U;
  end

  // Unrolled LFSRs. run* is the state after W steps (one data word); warm* is
  // the state after warm_step steps, tapped off the same chain.
  always_comb begin
    run1  = lfsr1_q;
    run2  = lfsr2_q;
    run3  = lfsr3_q;
    warm1 = lfsr1_q;
    warm2 = lfsr2_q;
    warm3 = lfsr3_q;
    ks    = '0;
    for (int j = 0; j < W; j++) begin
      ks[j] = (run1[N1-1] & run2[N2-1]) ^ run3[N3-1];
      run1  = {run1[N1-2:0], ^(run1 & TAPS1)};
      run2  = {run2[N2-2:0], ^(run2 & TAPS2)};
      run3  = {run3[N3-2:0], ^(run3 & TAPS3)};
      if (32'(j) < warm_step) begin
        warm1 = run1;
        warm2 = run2;
        warm3 = run3;
      end
    end
  end

  // FSM: state register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  // FSM: next state; load wins from any state
  always_comb begin
    state_d = state_q;
    if (load) begin
      state_d = ST_LOAD;
    end else begin
      case (state_q)
        ST_IDLE:   state_d = ST_IDLE;
        ST_LOAD:   state_d = (WARMUP > 0) ? ST_WARMUP : ST_RUN;
        ST_WARMUP: if (warm_q <= W_U) state_d = ST_RUN;
        ST_RUN:    state_d = ST_RUN;
        default:   state_d = ST_IDLE;
      endcase
    end
  end

  // FSM: outputs
  always_comb begin
    busy    = (state_q == ST_LOAD) || (state_q == ST_WARMUP);
    s_ready = (state_q == ST_RUN) && (!m_valid_q || m_ready);
  end

  // s_ready deliberately does not look at load; load only masks the accept.
  assign accept = s_valid && s_ready && !load;

  always_comb begin
    lfsr1_d   = lfsr1_q;
    lfsr2_d   = lfsr2_q;
    lfsr3_d   = lfsr3_q;
    warm_d    = warm_q;
    m_valid_d = m_valid_q;
    m_data_d  = m_data_q;
    if (load) begin
      m_valid_d = 1'b0;
    end else begin
      case (state_q)
        ST_LOAD: begin
          // An all-zero seed would lock the LFSR at zero; force LSB instead.
          lfsr1_d = (seed1 == '0) ? {{(N1-1){1'b0}}, 1'b1} : seed1;
          lfsr2_d = (seed2 == '0) ? {{(N2-1){1'b0}}, 1'b1} : seed2;
          lfsr3_d = (seed3 == '0) ? {{(N3-1){1'b0}}, 1'b1} : seed3;
          warm_d  = WARMUP_U;
        end
        ST_WARMUP: begin
          lfsr1_d = warm1;
          lfsr2_d = warm2;
          lfsr3_d = warm3;
          warm_d  = warm_q - warm_step;
        end
        ST_RUN: begin
          if (accept) begin
            lfsr1_d   = run1;
            lfsr2_d   = run2;
            lfsr3_d   = run3;
            m_valid_d = 1'b1;
            m_data_d  = s_data ^ ks;
          end else if (m_ready) begin
            m_valid_d = 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      lfsr1_q   <= '0;
      lfsr2_q   <= '0;
      lfsr3_q   <= '0;
      warm_q    <= '0;
      m_valid_q <= 1'b0;
      m_data_q  <= '0;
    end else begin
      lfsr1_q   <= lfsr1_d;
      lfsr2_q   <= lfsr2_d;
      lfsr3_q   <= lfsr3_d;
      warm_q    <= warm_d;
      m_valid_q <= m_valid_d;
      m_data_q  <= m_data_d;
    end
  end

  assign m_valid = m_valid_q;
  assign m_data  = m_data_q;

`ifdef STREAM_CIPHER_WORD_COUNT_EN
  logic [31:0] word_count_q, word_count_d;

  always_comb begin
    word_count_d = word_count_q;
    if (load)        word_count_d = '0;
    else if (accept) word_count_d = word_count_q + 32'd1;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) word_count_q <= '0;
    else        word_count_q <= word_count_d;
  end

  assign word_count = word_count_q;
`endif

endmodule

// File: tb/tb_stream_cipher_w.sv
module tb_stream_cipher_w;

  logic clk;
  logic reset;
  int   checks;
  int   errors;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // W=4, WARMUP=0 instance for directed vectors
  logic [4:0] a_s1;
  logic [6:0] a_s2;
  logic [8:0] a_s3;
  logic       a_load, a_busy, a_sv, a_sr, a_mv, a_mr;
  logic [3:0] a_sd, a_md;
  logic [31:0] a_wc;

  // W=8, WARMUP=16 encrypt/decrypt pair sharing seeds and load
  logic [4:0] l_s1;
  logic [6:0] l_s2;
  logic [8:0] l_s3;
  logic       l_load;
  logic       e_busy, e_sv, e_sr, e_mv, e_mr;
  logic [7:0] e_sd, e_md;
  logic       d_busy, d_sv, d_sr, d_mv, d_mr;
  logic [7:0] d_sd, d_md;
  logic [31:0] e_wc, d_wc;

  assign d_sv = e_mv;
  assign d_sd = e_md;
  assign e_mr = d_sr;

  stream_cipher_w #(.W(4), .WARMUP(0)) dut_a (
    .clk(clk), .reset(reset), .seed1(a_s1), .seed2(a_s2), .seed3(a_s3),
    .load(a_load), .busy(a_busy), .s_valid(a_sv), .s_ready(a_sr), .s_data(a_sd),
    .m_valid(a_mv), .m_ready(a_mr), .m_data(a_md)
`ifdef STREAM_CIPHER_WORD_COUNT_EN
    , .word_count(a_wc)
`endif
  );

  stream_cipher_w #(.W(8), .WARMUP(16)) dut_enc (
    .clk(clk), .reset(reset), .seed1(l_s1), .seed2(l_s2), .seed3(l_s3),
    .load(l_load), .busy(e_busy), .s_valid(e_sv), .s_ready(e_sr), .s_data(e_sd),
    .m_valid(e_mv), .m_ready(e_mr), .m_data(e_md)
`ifdef STREAM_CIPHER_WORD_COUNT_EN
    , .word_count(e_wc)
`endif
  );

  stream_cipher_w #(.W(8), .WARMUP(16)) dut_dec (
    .clk(clk), .reset(reset), .seed1(l_s1), .seed2(l_s2), .seed3(l_s3),
    .load(l_load), .busy(d_busy), .s_valid(d_sv), .s_ready(d_sr), .s_data(d_sd),
    .m_valid(d_mv), .m_ready(d_mr), .m_data(d_md)
`ifdef STREAM_CIPHER_WORD_COUNT_EN
    , .word_count(d_wc)
`endif
  );

`ifndef STREAM_CIPHER_WORD_COUNT_EN
  assign a_wc = 32'd0;
  assign e_wc = 32'd0;
  assign d_wc = 32'd0;
`endif

  // Bit-serial reference keystream for the default lengths/taps (W=4 instance)
  logic [31:0] m1, m2, m3;

  task automatic mdl_seed(input logic [31:0] s1, input logic [31:0] s2, input logic [31:0] s3);
    m1 = (s1 == 0) ? 32'd1 : s1;
    m2 = (s2 == 0) ? 32'd1 : s2;
    m3 = (s3 == 0) ? 32'd1 : s3;
  endtask

  task automatic mdl_word(input int w, output logic [31:0] ks);
    ks = '0;
    for (int j = 0; j < w; j++) begin
      ks[j] = (m1[4] & m2[6]) ^ m3[8];
      m1 = {m1[30:0], m1[4] ^ m1[2]} & 32'h1F;
      m2 = {m2[30:0], m2[6] ^ m2[5]} & 32'h7F;
      m3 = {m3[30:0], m3[8] ^ m3[4]} & 32'h1FF;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Load the W=4 instance and step through LOAD into RUN
  task automatic load4(input logic [4:0] s1, input logic [6:0] s2, input logic [8:0] s3);
    a_s1 = s1; a_s2 = s2; a_s3 = s3;
    a_sv = 1'b0;
    a_load = 1'b1;
    tick();
    a_load = 1'b0;
    tick();
  endtask

  task automatic test_reset();
    #2;
    checks++; if (a_mv !== 1'b0) begin errors++; $display("FAIL reset_a_mvalid: got %b expected 0", a_mv); end
    checks++; if (a_md !== 4'h0) begin errors++; $display("FAIL reset_a_mdata: got %h expected 0", a_md); end
    checks++; if (a_busy !== 1'b0) begin errors++; $display("FAIL reset_a_busy: got %b expected 0", a_busy); end
    checks++; if (a_sr !== 1'b0) begin errors++; $display("FAIL reset_a_sready: got %b expected 0", a_sr); end
    checks++; if (e_md !== 8'h00) begin errors++; $display("FAIL reset_e_mdata: got %h expected 0", e_md); end
    #10;
    reset = 1'b1;
    tick();
    checks++; if (a_sr !== 1'b0) begin errors++; $display("FAIL idle_sready: got %b expected 0", a_sr); end
  endtask

  task automatic test_vectors();
    a_mr = 1'b1;
    a_s1 = 5'b10101; a_s2 = 7'b1101101; a_s3 = 9'b101110011;
    a_load = 1'b1;
    tick();
    a_load = 1'b0;
    checks++; if (a_busy !== 1'b1) begin errors++; $display("FAIL load_busy: got %b expected 1", a_busy); end
    tick();
    checks++; if (a_sr !== 1'b1 || a_busy !== 1'b0) begin errors++; $display("FAIL run_entry: got sready=%b busy=%b expected 1/0", a_sr, a_busy); end
    a_sv = 1'b1; a_sd = 4'h0;
    tick();
    checks++; if (a_mv !== 1'b1 || a_md !== 4'hC) begin errors++; $display("FAIL vec0_zero: got v=%b d=%h expected 1/c", a_mv, a_md); end
    tick();
    checks++; if (a_md !== 4'h8) begin errors++; $display("FAIL vec1_zero: got %h expected 8", a_md); end
    a_sv = 1'b0;
    tick();
    checks++; if (a_mv !== 1'b0) begin errors++; $display("FAIL mvalid_clear: got %b expected 0", a_mv); end
    load4(5'b10101, 7'b1101101, 9'b101110011);
    a_sv = 1'b1; a_sd = 4'hF;
    tick();
    checks++; if (a_md !== 4'h3) begin errors++; $display("FAIL vec0_ones: got %h expected 3", a_md); end
    tick();
    checks++; if (a_md !== 4'h7) begin errors++; $display("FAIL vec1_ones: got %h expected 7", a_md); end
    a_sv = 1'b0;
    tick();
  endtask

  task automatic test_backpressure();
    load4(5'b10101, 7'b1101101, 9'b101110011);
    a_mr = 1'b0; a_sv = 1'b1; a_sd = 4'h0;
    tick();
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (a_mv !== 1'b1 || a_md !== 4'hC || a_sr !== 1'b0) begin
        errors++;
        $display("FAIL stall_hold[%0d]: got v=%b d=%h rdy=%b expected 1/c/0", i, a_mv, a_md, a_sr);
      end
      tick();
    end
    a_mr = 1'b1;
    tick();
    checks++; if (a_md !== 4'h8) begin errors++; $display("FAIL after_stall: got %h expected 8", a_md); end
    a_sv = 1'b0;
    tick();
  endtask

  task automatic test_zero_seed();
    logic [31:0] ks;
    int nz;
    nz = 0;
    load4(5'd0, 7'd0, 9'd0);
    mdl_seed(0, 0, 0);
    a_mr = 1'b1; a_sv = 1'b1; a_sd = 4'h0;
    for (int i = 0; i < 64; i++) begin
      tick();
      mdl_word(4, ks);
      checks++;
      if (a_md !== ks[3:0]) begin errors++; $display("FAIL zero_seed_ks[%0d]: got %h expected %h", i, a_md, ks[3:0]); end
      if (a_md != 4'h0) nz++;
    end
    a_sv = 1'b0;
    checks++; if (nz == 0) begin errors++; $display("FAIL zero_seed_nonconst: got %0d nonzero words expected >0", nz); end
    tick();
  endtask

  task automatic test_load_midrun();
    load4(5'b10101, 7'b1101101, 9'b101110011);
    a_sv = 1'b1; a_sd = 4'h0; a_mr = 1'b0;
    tick();
    checks++; if (a_mv !== 1'b1) begin errors++; $display("FAIL midrun_pre: got %b expected 1", a_mv); end
    a_mr = 1'b1; a_load = 1'b1; a_sd = 4'hF;
    tick();
    a_load = 1'b0;
    checks++; if (a_mv !== 1'b0 || a_busy !== 1'b1) begin errors++; $display("FAIL midrun_drop: got v=%b busy=%b expected 0/1", a_mv, a_busy); end
    tick();
    checks++; if (a_mv !== 1'b0 || a_sr !== 1'b1) begin errors++; $display("FAIL midrun_norun_accept: got v=%b rdy=%b expected 0/1", a_mv, a_sr); end
    tick();
    checks++; if (a_mv !== 1'b1 || a_md !== 4'h3) begin errors++; $display("FAIL midrun_first: got v=%b d=%h expected 1/3", a_mv, a_md); end
    a_sv = 1'b0;
    tick();
  endtask

  task automatic test_loopback();
    logic [7:0] pt [256];
    int idx, got, cidx, diff, cyc;
    logic fin, fout, fmid;
    logic [7:0] dout, cout;
    for (int i = 0; i < 256; i++) pt[i] = 8'($urandom);
    l_s1 = 5'b10101; l_s2 = 7'b1101101; l_s3 = 9'b101110011;
    e_sv = 1'b0; d_mr = 1'b1;
    l_load = 1'b1;
    tick();
    l_load = 1'b0;
    for (int i = 0; i < 3; i++) begin
      checks++; if (e_sr !== 1'b0 || e_busy !== 1'b1) begin errors++; $display("FAIL warm_cycle[%0d]: got rdy=%b busy=%b expected 0/1", i, e_sr, e_busy); end
      tick();
    end
    checks++; if (e_sr !== 1'b1) begin errors++; $display("FAIL first_sready: got %b expected 1", e_sr); end
    idx = 0; got = 0; cidx = 0; diff = 0; cyc = 0;
    while (got < 256 && cyc < 3000) begin
      e_sv = (idx < 256);
      e_sd = (idx < 256) ? pt[idx] : 8'h00;
      d_mr = ($urandom_range(0, 3) != 0);
      #1;
      fin = e_sv & e_sr;
      fmid = e_mv & e_mr;
      fout = d_mv & d_mr;
      dout = d_md;
      cout = e_md;
      @(posedge clk);
      #1;
      if (fin) idx++;
      if (fmid) begin
        if (cidx < 256 && cout != pt[cidx]) diff++;
        cidx++;
      end
      if (fout) begin
        checks++;
        if (dout !== pt[got]) begin errors++; $display("FAIL loopback[%0d]: got %h expected %h", got, dout, pt[got]); end
        got++;
      end
      cyc++;
    end
    e_sv = 1'b0; d_mr = 1'b1;
    checks++; if (got != 256) begin errors++; $display("FAIL loopback_timeout: got %0d words expected 256", got); end
    checks++; if (diff == 0) begin errors++; $display("FAIL ciphertext_differs: got %0d differing words expected >0", diff); end
    tick();
  endtask

  task automatic test_async_reset();
    load4(5'b10101, 7'b1101101, 9'b101110011);
    a_sv = 1'b1; a_sd = 4'h0; a_mr = 1'b0;
    tick();
    a_sv = 1'b0;
    l_load = 1'b1;
    tick();
    l_load = 1'b0;
    tick();
    checks++; if (e_busy !== 1'b1 || a_mv !== 1'b1) begin errors++; $display("FAIL pre_reset: got busy=%b v=%b expected 1/1", e_busy, a_mv); end
    #3;
    reset = 1'b0;
    #1;
    checks++; if (e_busy !== 1'b0) begin errors++; $display("FAIL areset_busy: got %b expected 0", e_busy); end
    checks++; if (a_mv !== 1'b0 || a_md !== 4'h0 || a_sr !== 1'b0) begin errors++; $display("FAIL areset_out: got v=%b d=%h rdy=%b expected 0/0/0", a_mv, a_md, a_sr); end
    #2;
    reset = 1'b1;
    a_mr = 1'b1;
    tick();
    checks++; if (e_busy !== 1'b0 || a_sr !== 1'b0) begin errors++; $display("FAIL post_reset_idle: got busy=%b rdy=%b expected 0/0", e_busy, a_sr); end
  endtask

  task automatic test_word_count();
`ifdef STREAM_CIPHER_WORD_COUNT_EN
    checks++; if (a_wc !== 32'd0) begin errors++; $display("FAIL wc_reset: got %0d expected 0", a_wc); end
    load4(5'b10101, 7'b1101101, 9'b101110011);
    a_mr = 1'b1; a_sv = 1'b1; a_sd = 4'h5;
    for (int i = 0; i < 10; i++) tick();
    a_sv = 1'b0;
    tick();
    checks++; if (a_wc !== 32'd10) begin errors++; $display("FAIL wc_count: got %0d expected 10", a_wc); end
    a_load = 1'b1;
    tick();
    a_load = 1'b0;
    checks++; if (a_wc !== 32'd0) begin errors++; $display("FAIL wc_clear: got %0d expected 0", a_wc); end
    tick();
`endif
  endtask

  initial begin
    checks = 0; errors = 0;
    reset = 1'b0;
    a_s1 = '0; a_s2 = '0; a_s3 = '0; a_load = 1'b0; a_sv = 1'b0; a_sd = '0; a_mr = 1'b0;
    l_s1 = '0; l_s2 = '0; l_s3 = '0; l_load = 1'b0; e_sv = 1'b0; e_sd = '0; d_mr = 1'b1;
    test_reset();
    test_vectors();
    test_backpressure();
    test_zero_seed();
    test_load_midrun();
    test_loopback();
    test_async_reset();
    test_word_count();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
